irq_dispatch32: RTL and testbench

Interrupt dispatcher between 32 peripheral request lines and the single INTERRUPT/INTERRUPT_ACK pair of a KCPSM3 processor. It latches rising edges on IRQ[31:0] into a pending register and raises INTERRUPT while any enabled source is pending. On INTERRUPT_ACK it selects the lowest-index enabled pending source, clears that source and presents its number as VECTOR on an input port until the interrupt service routine writes CLEAR. It is the servicing end of the wide-OR request merge: the OR of the pending sources causes the interrupt, and this block resolves which source it was.

---
 rtl/irq_dispatch_pkg.sv | 16 +
 rtl/prio_enc32.sv | 24 ++
 rtl/irq_dispatch32.sv | 118 +++++++++++
 tb/tb_irq_dispatch32.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_dispatch_pkg.sv
// Shared constants and FSM state type for the 32-source interrupt dispatcher.
// Latency: n/a (types only).
// Backpressure: n/a.
package irq_dispatch_pkg;

    localparam int NUM_SRC = 32;
    localparam int ID_W = 5;
    localparam logic [ID_W-1:0] SPURIOUS_ID = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

endpackage

// File: rtl/prio_enc32.sv
// Lowest-index-first priority encoder over 32 request bits; found is the OR-reduction.
// Latency: combinational.
// Backpressure: none.
module prio_enc32
    import irq_dispatch_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               found
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign found = |req;

endmodule

// File: rtl/irq_dispatch32.sv
// Latches IRQ rising edges, raises INTERRUPT, resolves the serviced source on ACK.
// Latency: edge -> PENDING 1 cycle, -> INTERRUPT 2 cycles; ACK -> VECTOR/VALID 1 cycle.
// Backpressure: one source in service at a time; new edges keep accumulating in PENDING.
module irq_dispatch32
    import irq_dispatch_pkg::*;
#(
    parameter LOC = "UNPLACED"
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic [NUM_SRC-1:0] MASK,
    output logic               INTERRUPT,
    input  logic               INTERRUPT_ACK,
    output logic [ID_W-1:0]    VECTOR,
    output logic               VALID,
    output logic               SPURIOUS,
    input  logic               CLEAR,
    output logic [NUM_SRC-1:0] PENDING,
    output logic               ANY
);

    // LOC is a placement hint only; this block just anchors the reference.
    if (LOC == 0) begin : g_loc_unset
    end

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_vec;
    logic               int_q, int_d;
    logic               vld_q, vld_d;
    logic               spur_q, spur_d;
    logic [ID_W-1:0]    vec_q, vec_d;
    logic [ID_W-1:0]    enc_id;
    logic               enc_found;

    assign rise = IRQ & ~irq_q;

    prio_enc32 u_prio (
        .req   (pend_q & MASK),
        .id    (enc_id),
        .found (enc_found)
    );

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        vld_d   = vld_q;
        spur_d  = spur_q;
        vec_d   = vec_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (enc_found) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                // INTERRUPT stays up even if the source is masked off before ACK.
                if (INTERRUPT_ACK) begin
                    state_d = SERVICE;
                    int_d   = 1'b0;
                    vld_d   = 1'b1;
                    if (enc_found) begin
                        vec_d   = enc_id;
                        spur_d  = 1'b0;
                        clr_vec = NUM_SRC'(1) << enc_id;
                    end else begin
                        vec_d  = SPURIOUS_ID;
                        spur_d = 1'b1;
                    end
                end
            end
            SERVICE: begin
                if (CLEAR) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    spur_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new edge arriving with the acknowledge-clear keeps the bit pending.
        pend_d = (pend_q & ~clr_vec) | rise;
    end

    always_ff @(posedge CLK) begin
        irq_q <= IRQ;
        if (!RST_N) begin
            state_q <= IDLE;
            pend_q  <= '0;
            int_q   <= 1'b0;
            vld_q   <= 1'b0;
            spur_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            int_q   <= int_d;
            vld_q   <= vld_d;
            spur_q  <= spur_d;
            vec_q   <= vec_d;
        end
    end

    assign INTERRUPT = int_q;
    assign VALID     = vld_q;
    assign SPURIOUS  = spur_q;
    assign VECTOR    = vec_q;
    assign PENDING   = pend_q;
    assign ANY       = enc_found;

endmodule

// File: tb/tb_irq_dispatch32.sv
// Directed bench for irq_dispatch32: expected service responses go into a queue,
// a monitor pops one each time VALID rises; level checks are made inline.
module tb_irq_dispatch32;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IRQ;
    logic [31:0] MASK;
    logic        INTERRUPT;
    logic        INTERRUPT_ACK;
    logic [4:0]  VECTOR;
    logic        VALID;
    logic        SPURIOUS;
    logic        CLEAR;
    logic [31:0] PENDING;
    logic        ANY;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] vec;
        logic       spur;
    } resp_t;

    resp_t exp_q[$];
    logic  vld_prev = 1'b0;

    irq_dispatch32 #(.LOC("UNPLACED")) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .IRQ           (IRQ),
        .MASK          (MASK),
        .INTERRUPT     (INTERRUPT),
        .INTERRUPT_ACK (INTERRUPT_ACK),
        .VECTOR        (VECTOR),
        .VALID         (VALID),
        .SPURIOUS      (SPURIOUS),
        .CLEAR         (CLEAR),
        .PENDING       (PENDING),
        .ANY           (ANY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_resp(input logic [4:0] vec, input logic spur);
        resp_t r;
        r.vec  = vec;
        r.spur = spur;
        exp_q.push_back(r);
    endtask

    task automatic ack_pulse();
        INTERRUPT_ACK = 1'b1;
        cyc();
        INTERRUPT_ACK = 1'b0;
    endtask

    task automatic clear_pulse();
        CLEAR = 1'b1;
        cyc();
        CLEAR = 1'b0;
    endtask

    // Monitor: compare each new service presentation against the scoreboard.
    always @(negedge CLK) begin
        if (VALID && !vld_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_service: got vector %0d spurious %0b, none expected", VECTOR, SPURIOUS);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("sb_vector", 32'(VECTOR), 32'(r.vec));
                check("sb_spurious", 32'(SPURIOUS), 32'(r.spur));
            end
        end
        vld_prev = VALID;
    end

    initial begin
        RST_N = 1'b0;
        IRQ = '0;
        MASK = '1;
        INTERRUPT_ACK = 1'b0;
        CLEAR = 1'b0;
        cyc();
        cyc();
        check("rst_interrupt", 32'(INTERRUPT), 0);
        check("rst_valid", 32'(VALID), 0);
        check("rst_spurious", 32'(SPURIOUS), 0);
        check("rst_vector", 32'(VECTOR), 0);
        check("rst_pending", PENDING, 0);
        check("rst_any", 32'(ANY), 0);
        RST_N = 1'b1;
        cyc();

        // ACK while idle is ignored.
        ack_pulse();
        check("idle_ack_valid", 32'(VALID), 0);

        // Single source.
        IRQ[5] = 1'b1;
        cyc();
        check("s1_pending", PENDING, 32'h0000_0020);
        check("s1_int_early", 32'(INTERRUPT), 0);
        check("s1_any", 32'(ANY), 1);
        IRQ[5] = 1'b0;
        cyc();
        check("s1_int", 32'(INTERRUPT), 1);
        expect_resp(5'd5, 1'b0);
        ack_pulse();
        check("s1_int_after_ack", 32'(INTERRUPT), 0);
        check("s1_valid", 32'(VALID), 1);
        check("s1_pending_clr", PENDING, 0);
        cyc();
        check("s1_valid_held", 32'(VALID), 1);
        clear_pulse();
        check("s1_valid_clr", 32'(VALID), 0);
        cyc();
        check("s1_idle_int", 32'(INTERRUPT), 0);

        // Priority: 3 and 17 together.
        IRQ[3] = 1'b1;
        IRQ[17] = 1'b1;
        cyc();
        IRQ = '0;
        cyc();
        check("pr_int", 32'(INTERRUPT), 1);
        expect_resp(5'd3, 1'b0);
        ack_pulse();
        check("pr_pending_17", PENDING, 32'h0002_0000);
        clear_pulse();
        check("pr_dead_cycle", 32'(INTERRUPT), 0);
        cyc();
        check("pr_reassert", 32'(INTERRUPT), 1);
        expect_resp(5'd17, 1'b0);
        ack_pulse();
        check("pr_pending_0", PENDING, 0);
        clear_pulse();

        // Masking.
        MASK = ~32'h0000_0200;
        IRQ[9] = 1'b1;
        cyc();
        IRQ[9] = 1'b0;
        check("mk_pending", PENDING, 32'h0000_0200);
        check("mk_any", 32'(ANY), 0);
        cyc();
        check("mk_no_int", 32'(INTERRUPT), 0);
        MASK = '1;
        #1;
        check("mk_any_en", 32'(ANY), 1);
        cyc();
        check("mk_int", 32'(INTERRUPT), 1);
        expect_resp(5'd9, 1'b0);
        ack_pulse();
        clear_pulse();

        // Spurious: source masked after request.
        IRQ[2] = 1'b1;
        cyc();
        IRQ[2] = 1'b0;
        cyc();
        check("sp_int", 32'(INTERRUPT), 1);
        MASK = ~32'h0000_0004;
        #1;
        check("sp_any", 32'(ANY), 0);
        cyc();
        check("sp_int_held", 32'(INTERRUPT), 1);
        expect_resp(5'd31, 1'b1);
        ack_pulse();
        check("sp_pending_kept", PENDING, 32'h0000_0004);
        check("sp_flag", 32'(SPURIOUS), 1);
        clear_pulse();
        check("sp_flag_clr", 32'(SPURIOUS), 0);
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        MASK = '1;
        cyc();
        check("sp_reset_pending", PENDING, 0);

        // Collision: new edge on 4 coincides with ACK of 4.
        IRQ[4] = 1'b1;
        cyc();
        IRQ[4] = 1'b0;
        cyc();
        check("co_int", 32'(INTERRUPT), 1);
        expect_resp(5'd4, 1'b0);
        IRQ[4] = 1'b1;
        ack_pulse();
        IRQ[4] = 1'b0;
        check("co_pending", PENDING, 32'h0000_0010);
        check("co_valid", 32'(VALID), 1);
        clear_pulse();
        cyc();
        check("co_reassert", 32'(INTERRUPT), 1);
        expect_resp(5'd4, 1'b0);
        ack_pulse();
        check("co_pending_0", PENDING, 0);
        clear_pulse();

        // Reset mid-service with IRQ[0] held high.
        IRQ[0] = 1'b1;
        cyc();
        cyc();
        check("rs_int", 32'(INTERRUPT), 1);
        expect_resp(5'd0, 1'b0);
        ack_pulse();
        check("rs_valid", 32'(VALID), 1);
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        check("rs_interrupt", 32'(INTERRUPT), 0);
        check("rs_valid_0", 32'(VALID), 0);
        check("rs_spurious", 32'(SPURIOUS), 0);
        check("rs_vector", 32'(VECTOR), 0);
        check("rs_pending", PENDING, 0);
        cyc();
        cyc();
        cyc();
        check("rs_no_int", 32'(INTERRUPT), 0);
        check("rs_no_pending", PENDING, 0);
        IRQ = '0;
        cyc();
        cyc();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
